// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a shared BCD-to-7seg decoder.
// Double-buffered digit data swaps only at frame boundaries; supports blank gap and blinking.
module seg_scan_ctrl #(
  parameter int NDIG         = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] digits_in,
  input  logic [NDIG-1:0]   dots_in,
  input  logic [NDIG-1:0]   blink_mask,
  output logic              pending,
  output logic [3:0]        bcd_out,
  output logic              dot_out,
  output logic [NDIG-1:0]   an_out,
  output logic              frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NDIG - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]            prescaler_q, prescaler_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [BW-1:0]            blink_cnt_q, blink_cnt_d;
  logic                     phase_q, phase_d;
  logic [NDIG-1:0][3:0]     act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NDIG-1:0]          act_dot_q, act_dot_d, pend_dot_q, pend_dot_d;
  logic [NDIG-1:0]          act_blink_q, act_blink_d, pend_blink_q, pend_blink_d;
  logic                     pending_q, pending_d;
  logic [3:0]               bcd_q, bcd_d;
  logic                     dot_q, dot_d;
  logic [NDIG-1:0]          an_q, an_d;
  logic                     frame_done_q, frame_done_d;
  logic                     tick, boundary;

  always_comb begin
    tick         = (prescaler_q == PRE_MAX);
    boundary     = tick && (idx_q == IDX_MAX);
    prescaler_d  = tick ? '0 : prescaler_q + 1'b1;
    idx_d        = idx_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    act_dig_d    = act_dig_q;
    act_dot_d    = act_dot_q;
    act_blink_d  = act_blink_q;
    pend_dig_d   = pend_dig_q;
    pend_dot_d   = pend_dot_q;
    pend_blink_d = pend_blink_q;
    pending_d    = pending_q;

    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    if (boundary) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // A load landing on the boundary bypasses the pending buffer entirely.
    if (boundary) begin
      if (load) begin
        act_dig_d   = digits_in;
        act_dot_d   = dots_in;
        act_blink_d = blink_mask;
      end else if (pending_q) begin
        act_dig_d   = pend_dig_q;
        act_dot_d   = pend_dot_q;
        act_blink_d = pend_blink_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pend_dig_d   = digits_in;
      pend_dot_d   = dots_in;
      pend_blink_d = blink_mask;
      pending_d    = 1'b1;
    end

    bcd_d        = act_dig_q[idx_q];
    dot_d        = ~act_dot_q[idx_q];
    frame_done_d = boundary;
    an_d         = '1;
    if (!(prescaler_q < PRE_BLANK) && !(phase_q && act_blink_q[idx_q])) begin
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q  <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      act_dig_q    <= '0;
      act_dot_q    <= '0;
      act_blink_q  <= '0;
      pend_dig_q   <= '0;
      pend_dot_q   <= '0;
      pend_blink_q <= '0;
      pending_q    <= 1'b0;
      bcd_q        <= '0;
      dot_q        <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      act_dig_q    <= act_dig_d;
      act_dot_q    <= act_dot_d;
      act_blink_q  <= act_blink_d;
      pend_dig_q   <= pend_dig_d;
      pend_dot_q   <= pend_dot_d;
      pend_blink_q <= pend_blink_d;
      pending_q    <= pending_d;
      bcd_q        <= bcd_d;
      dot_q        <= dot_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pending    = pending_q;
  assign bcd_out    = bcd_q;
  assign dot_out    = dot_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random loads,
// compared against a frame/slot arithmetic model of the display.
module tb_seg_scan_ctrl;

  localparam int NDIG   = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int BFR    = 2;
  localparam int FRAME  = NDIG * DIV;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load = 1'b0;
  logic [4*NDIG-1:0] digits_in = '0;
  logic [NDIG-1:0]   dots_in = '0;
  logic [NDIG-1:0]   blink_mask = '0;
  logic              pending;
  logic [3:0]        bcd_out;
  logic              dot_out;
  logic [NDIG-1:0]   an_out;
  logic              frame_done;

  int testsRun = 0;
  int testsFailed = 0;

  // Model: n counts clock edges since reset release; the display content of
  // the current frame lives in m_dig/m_dot/m_blink, queued data in p_*.
  int              n = 0;
  logic [15:0]     m_dig, p_dig;
  logic [3:0]      m_dot, p_dot, m_blink, p_blink;
  bit              m_pend;

  seg_scan_ctrl #(
    .NDIG(NDIG), .SCAN_DIV(DIV), .BLANK_CYC(BLANK), .BLINK_FRAMES(BFR)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
    .dots_in(dots_in), .blink_mask(blink_mask), .pending(pending),
    .bcd_out(bcd_out), .dot_out(dot_out), .an_out(an_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s (edge %0d): got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check at negedge.
  task automatic applyStimulus(input bit ld, input logic [15:0] dig, input logic [3:0] dt,
                               input logic [3:0] bm);
    int          p, i, f;
    bit          ph, bnd;
    logic [3:0]  e_bcd, e_an;
    logic        e_dot;
    load = ld; digits_in = dig; dots_in = dt; blink_mask = bm;
    @(posedge clk);
    p   = n % DIV;
    i   = (n / DIV) % NDIG;
    f   = n / FRAME;
    ph  = ((f / BFR) % 2) == 1;
    bnd = (n % FRAME) == FRAME - 1;
    e_bcd = m_dig[i*4 +: 4];
    e_dot = ~m_dot[i];
    e_an  = 4'hF;
    if (p >= BLANK && !(ph && m_blink[i])) e_an[i] = 1'b0;
    if (ld) begin
      if (bnd) begin
        m_dig = dig; m_dot = dt; m_blink = bm; m_pend = 0;
      end else begin
        p_dig = dig; p_dot = dt; p_blink = bm; m_pend = 1;
      end
    end else if (bnd && m_pend) begin
      m_dig = p_dig; m_dot = p_dot; m_blink = p_blink; m_pend = 0;
    end
    n++;
    @(negedge clk);
    checkOutput("bcd_out", 32'(bcd_out), 32'(e_bcd));
    checkOutput("dot_out", 32'(dot_out), 32'(e_dot));
    checkOutput("an_out", 32'(an_out), 32'(e_an));
    checkOutput("frame_done", 32'(frame_done), 32'(bnd));
    checkOutput("pending", 32'(pending), 32'(m_pend));
    load = 1'b0;
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    load = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_an", 32'(an_out), 32'hF);
    checkOutput("rst_bcd", 32'(bcd_out), 32'h0);
    checkOutput("rst_dot", 32'(dot_out), 32'h1);
    checkOutput("rst_pending", 32'(pending), 32'h0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
    m_dig = '0; m_dot = '0; m_blink = '0; m_pend = 0; n = 0;
    rst = 1'b0;
  endtask

  task automatic idleUntil(input int target);
    while (n < target) applyStimulus(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  initial begin
    logic [31:0] r;
    p_dig = '0; p_dot = '0; p_blink = '0;
    doReset(3);

    // Mid-frame load, then a full display frame
    idleUntil(5);
    applyStimulus(1'b1, 16'h1234, 4'b0100, 4'b0000);
    idleUntil(2 * FRAME);

    // Two loads in one frame: last wins
    idleUntil(2 * FRAME + 6);
    applyStimulus(1'b1, 16'h1111, 4'b0000, 4'b0000);
    idleUntil(2 * FRAME + 11);
    applyStimulus(1'b1, 16'h5678, 4'b1001, 4'b0000);

    // Load exactly on the boundary cycle
    idleUntil(4 * FRAME - 1);
    applyStimulus(1'b1, 16'h9999, 4'b0010, 4'b0000);

    // Blink on digit 0 across several blink periods
    idleUntil(4 * FRAME + 3);
    applyStimulus(1'b1, 16'h4321, 4'b0000, 4'b0001);
    idleUntil(13 * FRAME);

    // Reset in slot 2 while data is pending
    idleUntil(13 * FRAME + 2 * DIV + 3);
    applyStimulus(1'b1, 16'h8765, 4'b1111, 4'b1111);
    checkOutput("pending_before_rst", 32'(pending), 32'h1);
    doReset(2);
    idleUntil(2 * FRAME);

    // Random loads, with extra weight on boundary-cycle loads
    for (int k = 0; k < 3000; k++) begin
      r = $urandom;
      if ((r[3:0] == 4'h0) || ((n % FRAME) == FRAME - 1 && r[5:4] == 2'b00))
        applyStimulus(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else
        applyStimulus(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
